// File: rtl/data_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through data cache controller:
// default geometry, controller state encoding and the statistics counter helper.
package data_cache_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF   = 10;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int INDEX_WIDTH_DEF  = 5;
  localparam int OFFSET_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_cache_ctrl_line_array.sv
// Valid/tag/data storage for the data cache: combinational read by index/offset,
// synchronous word write and line install, valid bits cleared asynchronously on rst.
module cache_line_array #(
  parameter int INDEX_WIDTH  = 5,
  parameter int OFFSET_WIDTH = 2,
  parameter int TAG_WIDTH    = 3,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_WIDTH-1:0]  rd_index_i,
  input  logic [OFFSET_WIDTH-1:0] rd_offset_i,
  output logic                    rd_valid_o,
  output logic [TAG_WIDTH-1:0]    rd_tag_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    wr_en_i,
  input  logic [INDEX_WIDTH-1:0]  wr_index_i,
  input  logic [OFFSET_WIDTH-1:0] wr_offset_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    set_en_i,
  input  logic [INDEX_WIDTH-1:0]  set_index_i,
  input  logic [TAG_WIDTH-1:0]    set_tag_i
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = LINES << OFFSET_WIDTH;

  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [WORDS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];

  // A line only becomes valid once its whole block has been installed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {LINES{1'b0}};
    end else if (set_en_i) begin
      valid_q[set_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
    end
    if (set_en_i) begin
      tag_q[set_index_i] <= set_tag_i;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional hit/miss statistics outputs are enabled with CACHE_STATS_EN.
module data_cache_ctrl
  import data_cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam logic [OFFSET_WIDTH-1:0] CNT_ZERO = {OFFSET_WIDTH{1'b0}};
  localparam logic [OFFSET_WIDTH-1:0] CNT_ONE  = {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = {OFFSET_WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic [TAG_WIDTH-1:0]    cpu_tag_s;
  logic [INDEX_WIDTH-1:0]  cpu_index_s;
  logic [OFFSET_WIDTH-1:0] cpu_offset_s;
  logic                    line_valid_s;
  logic [TAG_WIDTH-1:0]    line_tag_s;
  logic [DATA_WIDTH-1:0]   line_word_s;
  logic                    hit_s;

  logic                    arr_we_s;
  logic [INDEX_WIDTH-1:0]  arr_index_s;
  logic [OFFSET_WIDTH-1:0] arr_offset_s;
  logic [DATA_WIDTH-1:0]   arr_wdata_s;
  logic                    arr_set_s;
  logic                    stall_s;
  logic [DATA_WIDTH-1:0]   rdata_s;
  logic                    access_s;
  logic                    refill_done_s;

  assign cpu_tag_s    = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign cpu_index_s  = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cpu_offset_s = cpu_addr[OFFSET_WIDTH-1:0];
  assign hit_s        = line_valid_s && (line_tag_s == cpu_tag_s);

  cache_line_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (cpu_index_s),
    .rd_offset_i(cpu_offset_s),
    .rd_valid_o (line_valid_s),
    .rd_tag_o   (line_tag_s),
    .rd_data_o  (line_word_s),
    .wr_en_i    (arr_we_s),
    .wr_index_i (arr_index_s),
    .wr_offset_i(arr_offset_s),
    .wr_data_i  (arr_wdata_s),
    .set_en_i   (arr_set_s),
    .set_index_i(mem_addr_q[OFFSET_WIDTH +: INDEX_WIDTH]),
    .set_tag_i  (mem_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH])
  );

  // Controller next-state, array write port and CPU-side responses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    arr_we_s      = 1'b0;
    arr_index_s   = cpu_index_s;
    arr_offset_s  = cpu_offset_s;
    arr_wdata_s   = cpu_wdata;
    arr_set_s     = 1'b0;
    stall_s       = 1'b0;
    rdata_s       = {DATA_WIDTH{1'b0}};
    access_s      = 1'b0;
    refill_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          access_s    = 1'b1;
          stall_s     = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          arr_we_s    = hit_s;
          state_d     = WRITE;
        end else if (cpu_rd) begin
          access_s = 1'b1;
          if (hit_s) begin
            rdata_s = line_word_s;
          end else begin
            stall_s    = 1'b1;
            cnt_d      = CNT_ZERO;
            mem_addr_d = {cpu_tag_s, cpu_index_s, CNT_ZERO};
            state_d    = REFILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        stall_s = 1'b1;
        if (mem_ready) begin
          arr_we_s     = 1'b1;
          arr_index_s  = mem_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
          arr_offset_s = cnt_q;
          arr_wdata_s  = mem_rdata;
          cnt_d        = cnt_q + CNT_ONE;
          mem_addr_d   = {mem_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], cnt_q + CNT_ONE};
          if (cnt_q == CNT_LAST) begin
            arr_set_s     = 1'b1;
            refill_done_s = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      WRITE: begin
        stall_s = !mem_ready;
        if (mem_ready) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, refill counter and memory-side request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Reset releases the pipeline at once, even with a request still held.
  assign stall     = stall_s && !rst;
  assign cpu_rdata = rst ? {DATA_WIDTH{1'b0}} : rdata_s;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = (state_q == REFILL);
  assign mem_wr    = (state_q == WRITE);

`ifdef CACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // The read retried right after a refill is the same access, so it is not recounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q      <= 1'b0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      retry_q <= refill_done_s;
      if (access_s && !retry_q) begin
        if (hit_s) begin
          hit_count_q <= sat_inc(hit_count_q);
        end else begin
          miss_count_q <= sat_inc(miss_count_q);
        end
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed scoreboard bench for data_cache_ctrl: a 2-cycle memory responder
// returning addr*3, expected load data and memory traffic queued at issue time.
`timescale 1ns/1ps
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wait_cnt = 0;

  logic [31:0] rd_q[$];
  logic [9:0]  refill_q[$];
  logic [41:0] wr_q[$];

  always #5 clk = ~clk;

  data_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: every request word completes two cycles after the previous one.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if ((mem_rd || mem_wr) && !rst) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          wait_cnt  = 0;
          mem_ready = 1'b1;
          mem_rdata = {22'd0, mem_addr} * 32'd3;
          if (mem_rd) begin
            if (refill_q.size() == 0) check("refill_unexpected", {22'd0, mem_addr}, 32'hFFFF_FFFF);
            else check("refill_addr", {22'd0, mem_addr}, {22'd0, refill_q.pop_front()});
          end else begin
            if (wr_q.size() == 0) check("write_unexpected", {22'd0, mem_addr}, 32'hFFFF_FFFF);
            else begin
              logic [41:0] e;
              e = wr_q.pop_front();
              check("write_addr", {22'd0, mem_addr}, {22'd0, e[41:32]});
              check("write_data", mem_wdata, e[31:0]);
            end
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_read(input logic [9:0] a, input logic miss, input logic [31:0] exp);
    int cycles;
    cpu_addr = a;
    cpu_rd   = 1'b1;
    rd_q.push_back(exp);
    if (miss) begin
      for (int i = 0; i < 4; i++) refill_q.push_back({a[9:2], 2'(i)});
    end
    @(negedge clk);
    check($sformatf("rd_stall_first_%h", a), {31'd0, stall}, {31'd0, miss});
    cycles = 0;
    while (stall && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check($sformatf("rd_latency_%h", a), cycles, miss ? 32'd9 : 32'd0);
    check($sformatf("rd_memrd_idle_%h", a), {31'd0, mem_rd}, 32'd0);
    check($sformatf("rd_data_%h", a), cpu_rdata, rd_q.pop_front());
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    int cycles;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    wr_q.push_back({a, d});
    @(negedge clk);
    check($sformatf("wr_stall_first_%h", a), {31'd0, stall}, 32'd1);
    cycles = 0;
    while (stall && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check($sformatf("wr_latency_%h", a), cycles, 32'd2);
    check($sformatf("wr_release_ready_%h", a), {30'd0, mem_wr, mem_ready}, 32'd3);
    @(posedge clk);
    #1;
    cpu_wr = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cpu_addr  = 10'd0;
    cpu_wdata = 32'd0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_mem_req", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_read(10'h004, 1'b1, 32'h0000_000C);
    do_read(10'h006, 1'b0, 32'h0000_0012);
    do_write(10'h005, 32'hDEAD_BEEF);
    do_read(10'h005, 1'b0, 32'hDEAD_BEEF);
    do_write(10'h3F0, 32'h1234_5678);
    do_read(10'h3F0, 1'b1, 32'h0000_0BD0);
    do_read(10'h084, 1'b1, 32'h0000_018C);
    do_read(10'h004, 1'b1, 32'h0000_000C);
`ifdef CACHE_STATS_EN
    check("stats_hits", hit_count, 32'd3);
    check("stats_misses", miss_count, 32'd5);
`endif

    // Abort a refill with reset while its second word is outstanding.
    cpu_addr = 10'h104;
    cpu_rd   = 1'b1;
    refill_q.push_back(10'h104);
    for (int i = 0; i < 10 && !mem_ready; i++) @(negedge clk);
    check("abort_first_word_ready", {31'd0, mem_ready}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
`ifdef CACHE_STATS_EN
    check("abort_hits", hit_count, 32'd0);
    check("abort_misses", miss_count, 32'd0);
`endif
    cpu_rd = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    refill_q.delete();
    @(negedge clk);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    do_read(10'h104, 1'b1, 32'h0000_030C);
    do_read(10'h004, 1'b1, 32'h0000_000C);

    check("rd_q_drained", rd_q.size(), 32'd0);
    check("refill_q_drained", refill_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
